// File: rtl/temporal_encoder_pkg.sv
// -----------------------------------------------------------------------------
// temporal_encoder_pkg
// Shared definitions for the temporal (N-gram) encoder slice.
//   - default hypervector width and N-gram length
//   - fill / output-slot state enums
//   - ceil_log2 helper used to size the fill counter
// -----------------------------------------------------------------------------
package temporal_encoder_pkg;

  parameter int HV_DIMENSION_DEFAULT = 2000;
  parameter int NGRAM_SIZE_DEFAULT   = 3;
  parameter int NGRAM_SIZE_MAX       = 8;

  // Fill FSM: FILLING until NGRAM_SIZE-1 vectors of history exist.
  typedef enum logic {
    FILLING = 1'b0,
    STEADY  = 1'b1
  } fill_state_e;

  // Output slot FSM: whether NGramOut_DO currently holds an unconsumed N-gram.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int ceil_log2(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/temporal_encoder_ngram_history.sv
// -----------------------------------------------------------------------------
// ngram_history
// Shift register of DEPTH hypervectors that are stored pre-rotated:
// slot k holds rho^(k+1) of the vector accepted k+1 shifts ago, so the
// N-gram is simply the new vector XORed with every slot.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset, clears all slots
//   clear    in   synchronous flush; with shift, only slot 0 is refilled
//   shift    in   accept strobe, shifts in rho(hv_in)
//   hv_in    in   [0:HV_DIMENSION-1] incoming spatial hypervector
//   hist_xor out  [0:HV_DIMENSION-1] XOR of all history slots
// -----------------------------------------------------------------------------
module ngram_history
  import temporal_encoder_pkg::*;
#(
  parameter int HV_DIMENSION = HV_DIMENSION_DEFAULT,
  parameter int DEPTH        = NGRAM_SIZE_DEFAULT - 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    shift,
  input  logic [0:HV_DIMENSION-1] hv_in,
  output logic [0:HV_DIMENSION-1] hist_xor
);

  logic [0:HV_DIMENSION-1] hist [DEPTH];

  // Rotate-on-shift history. Bit 0 is the MSB, so rho moves the last
  // element (LSB) round to index 0. A clear that coincides with a shift
  // starts a fresh window seeded with the incoming vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        hist[k] <= '0;
      end
    end else if (clear) begin
      for (int k = 0; k < DEPTH; k++) begin
        hist[k] <= '0;
      end
      if (shift) begin
        hist[0] <= {hv_in[HV_DIMENSION-1], hv_in[0:HV_DIMENSION-2]};
      end
    end else if (shift) begin
      hist[0] <= {hv_in[HV_DIMENSION-1], hv_in[0:HV_DIMENSION-2]};
      for (int k = 1; k < DEPTH; k++) begin
        hist[k] <= {hist[k-1][HV_DIMENSION-1], hist[k-1][0:HV_DIMENSION-2]};
      end
    end
  end

  // Combined contribution of all older vectors to the next N-gram.
  always_comb begin
    hist_xor = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hist_xor = hist_xor ^ hist[k];
    end
  end

endmodule

// File: rtl/temporal_encoder.sv
// -----------------------------------------------------------------------------
// temporal_encoder
// Binds each accepted spatial hypervector with the previous NGRAM_SIZE-1
// ones into an N-gram  S_t ^ rho(S_t-1) ^ rho^2(S_t-2) ^ ...  and presents it
// through a registered valid/ready slot to the associative memory.
// NGRAM_SIZE legal range is 1..8; 1 passes S_t straight through.
// Ports:
//   Clk_CI           in   clock, rising edge
//   Reset_RBI        in   asynchronous active-low reset
//   Clear_SI         in   synchronous flush of the N-gram history
//   ValidIn_SI       in   spatial hypervector valid
//   ReadyOut_SO      out  ready to accept a spatial hypervector
//   HypervectorIn_DI in   [0:HV_DIMENSION-1] spatial hypervector, bit 0 = MSB
//   ValidOut_SO      out  N-gram valid
//   ReadyIn_SI       in   downstream ready
//   NGramOut_DO      out  [0:HV_DIMENSION-1] registered N-gram
// -----------------------------------------------------------------------------
module temporal_encoder
  import temporal_encoder_pkg::*;
#(
  parameter int HV_DIMENSION = HV_DIMENSION_DEFAULT,
  parameter int NGRAM_SIZE   = NGRAM_SIZE_DEFAULT
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RBI,
  input  logic                    Clear_SI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [0:HV_DIMENSION-1] NGramOut_DO
);

  localparam int CNT_W = ceil_log2(NGRAM_SIZE);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(NGRAM_SIZE - 1);

  logic [CNT_W-1:0]        fill_cntr;
  logic [CNT_W-1:0]        fill_cntr_next;
  fill_state_e             fill_state;
  slot_state_e             slot_state;
  slot_state_e             slot_state_next;
  logic                    accept;
  logic                    clear_window;
  logic                    new_ngram;
  logic [0:HV_DIMENSION-1] hist_xor;
  logic [0:HV_DIMENSION-1] candidate;

  // With a single-vector N-gram there is no window to flush, so clear is
  // ignored and every accept produces an output.
  assign clear_window = Clear_SI && (NGRAM_SIZE > 1);
  assign accept       = ValidIn_SI && ReadyOut_SO;
  assign new_ngram    = accept && (fill_state == STEADY) && !clear_window;
  assign candidate    = HypervectorIn_DI ^ hist_xor;

  generate
    if (NGRAM_SIZE > 1) begin : g_history
      ngram_history #(
        .HV_DIMENSION (HV_DIMENSION),
        .DEPTH        (NGRAM_SIZE - 1)
      ) u_history (
        .clk      (Clk_CI),
        .rst_n    (Reset_RBI),
        .clear    (clear_window),
        .shift    (accept),
        .hv_in    (HypervectorIn_DI),
        .hist_xor (hist_xor)
      );
    end else begin : g_no_history
      assign hist_xor = '0;
    end
  endgenerate

  // State register for both FSMs: the saturating fill counter and the
  // output slot occupancy.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      fill_cntr  <= '0;
      slot_state <= EMPTY;
    end else begin
      fill_cntr  <= fill_cntr_next;
      slot_state <= slot_state_next;
    end
  end

  // Next-state logic. Clear restarts the window; an accept arriving with
  // the clear counts as the first vector of the new window.
  always_comb begin
    fill_cntr_next  = fill_cntr;
    slot_state_next = slot_state;
    if (clear_window) begin
      fill_cntr_next = accept ? CNT_W'(1) : '0;
    end else if (accept && (fill_state == FILLING)) begin
      fill_cntr_next = fill_cntr + 1'b1;
    end
    if (new_ngram) begin
      slot_state_next = FULL;
    end else if ((slot_state == FULL) && ReadyIn_SI) begin
      slot_state_next = EMPTY;
    end
  end

  // Output decode. ReadyOut depends only on registered state and the
  // downstream ready, never on ValidIn.
  always_comb begin
    fill_state  = (fill_cntr < FILL_MAX) ? FILLING : STEADY;
    ValidOut_SO = (slot_state == FULL);
    ReadyOut_SO = (slot_state == EMPTY) || ReadyIn_SI;
  end

  // Output data register: loaded only when a fresh N-gram is produced, so
  // it stays stable while the slot is stalled.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      NGramOut_DO <= '0;
    end else if (new_ngram) begin
      NGramOut_DO <= candidate;
    end
  end

endmodule

// File: tb/tb_temporal_encoder.sv
// -----------------------------------------------------------------------------
// tb_temporal_encoder
// Directed and random stimulus for temporal_encoder (HV_DIMENSION=8,
// NGRAM_SIZE=3) compared cycle by cycle against a window-based reference.
// -----------------------------------------------------------------------------
module tb_temporal_encoder;

  localparam int HV = 8;
  localparam int N  = 3;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          valid_in;
  logic          ready_out;
  logic [0:HV-1] hv_in;
  logic          valid_out;
  logic          ready_in;
  logic [0:HV-1] ngram_out;

  int n_compared;
  int n_mismatched;

  // Reference model: the last N accepted vectors since reset/clear, newest
  // first, plus the output slot contents.
  logic [7:0] win[$];
  logic       mv;
  logic [7:0] md;

  temporal_encoder #(
    .HV_DIMENSION (HV),
    .NGRAM_SIZE   (N)
  ) dut (
    .Clk_CI           (clk),
    .Reset_RBI        (rst_n),
    .Clear_SI         (clear),
    .ValidIn_SI       (valid_in),
    .ReadyOut_SO      (ready_out),
    .HypervectorIn_DI (hv_in),
    .ValidOut_SO      (valid_out),
    .ReadyIn_SI       (ready_in),
    .NGramOut_DO      (ngram_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Circular right rotate by k positions, in plain arithmetic.
  function automatic logic [7:0] rotr(input logic [7:0] x, input int k);
    int v;
    v = int'(x);
    return 8'(((v >> k) | (v << (HV - k))) & 255);
  endfunction

  function automatic logic [7:0] window_ngram();
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < win.size(); k++) begin
      r = r ^ rotr(win[k], k);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the reference model across one rising edge.
  task automatic model_edge(input logic vin, input logic [7:0] din, input logic rdy, input logic clr);
    logic acc;
    acc = vin && (!mv || rdy);
    if (mv && rdy) mv = 1'b0;
    if (clr) begin
      win.delete();
      if (acc) win.push_front(din);
    end else if (acc) begin
      win.push_front(din);
      if (win.size() > N) void'(win.pop_back());
      if (win.size() == N) begin
        mv = 1'b1;
        md = window_ngram();
      end
    end
  endtask

  task automatic model_reset();
    win.delete();
    mv = 1'b0;
    md = 8'h00;
  endtask

  // One clock cycle: drive inputs, check ready before the edge, then
  // check valid/data just after it.
  task automatic step(input logic vin, input logic [7:0] din, input logic rdy, input logic clr);
    valid_in = vin;
    hv_in    = din;
    ready_in = rdy;
    clear    = clr;
    #1;
    check("ready_out", 32'(ready_out), 32'(!mv || rdy));
    @(posedge clk);
    model_edge(vin, din, rdy, clr);
    #1;
    check("valid_out", 32'(valid_out), 32'(mv));
    if (mv) check("ngram_out", 32'(ngram_out), 32'(md));
  endtask

  initial begin
    logic [7:0] rnd_hv;
    int         accepted;
    int         cycles;
    logic       rdy_r;

    n_compared   = 0;
    n_mismatched = 0;
    rst_n    = 1'b0;
    clear    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    hv_in    = '0;
    model_reset();

    // Reset state
    #12;
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_data", 32'(ngram_out), 32'd0);
    rst_n = 1'b1;
    #1;
    check("reset_ready", 32'(ready_out), 32'd1);

    // Fill
    step(1'b1, 8'h80, 1'b1, 1'b0);
    step(1'b1, 8'h80, 1'b1, 1'b0);
    step(1'b1, 8'h80, 1'b1, 1'b0);
    check("fill_E0", 32'(ngram_out), 32'h0E0);

    // Steady and wrap of bit 7 into bit 0
    step(1'b1, 8'h01, 1'b1, 1'b0);
    check("steady_61", 32'(ngram_out), 32'h061);
    step(1'b1, 8'h01, 1'b1, 1'b0);
    step(1'b1, 8'h01, 1'b1, 1'b0);
    check("wrap_C1", 32'(ngram_out), 32'h0C1);

    // Back-pressure: output held, no accept for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      check("bp_hold", 32'(ngram_out), 32'h0C1);
    end
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    check("bp_release", 32'(ngram_out), 32'h065);

    // Clear alone: two silent accepts, output on the third
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'h11, 1'b1, 1'b0);
    check("clr_acc1", 32'(valid_out), 32'd0);
    step(1'b1, 8'h12, 1'b1, 1'b0);
    check("clr_acc2", 32'(valid_out), 32'd0);
    step(1'b1, 8'h13, 1'b1, 1'b0);
    check("clr_acc3", 32'(valid_out), 32'd1);

    // Clear with simultaneous accept: two more accepts complete the window
    step(1'b1, 8'h22, 1'b1, 1'b1);
    check("clracc_0", 32'(valid_out), 32'd0);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    check("clracc_1", 32'(valid_out), 32'd0);
    step(1'b1, 8'h44, 1'b1, 1'b0);
    check("clracc_2", 32'(valid_out), 32'd1);

    // Async reset with an output pending
    step(1'b1, 8'h55, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(valid_out), 32'd0);
    check("async_data", 32'(ngram_out), 32'd0);
    check("async_ready", 32'(ready_out), 32'd1);
    model_reset();
    #10;
    rst_n = 1'b1;
    step(1'b1, 8'h66, 1'b1, 1'b0);
    check("refill_1", 32'(valid_out), 32'd0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("refill_2", 32'(valid_out), 32'd0);
    step(1'b1, 8'h88, 1'b1, 1'b0);
    check("refill_3", 32'(valid_out), 32'd1);

    // Random throughput: 100 vectors, downstream ready ~50%
    accepted = 0;
    cycles   = 0;
    rnd_hv   = 8'($urandom);
    while (accepted < 100 && cycles < 2000) begin
      rdy_r = 1'($urandom_range(0, 1));
      if (!mv || rdy_r) begin
        accepted++;
        step(1'b1, rnd_hv, rdy_r, 1'b0);
        rnd_hv = 8'($urandom);
      end else begin
        step(1'b1, rnd_hv, rdy_r, 1'b0);
      end
      cycles++;
    end
    check("random_accepts", 32'(accepted), 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
